fetch_unit: RTL

Instruction fetch and program-counter stage for the ARM core. It holds the PC, issues 16-bit instruction fetches over a req/ack memory port, and presents fetched instructions to the decoder through a one-entry valid/ready buffer. It resolves conditional branches using `do_branch` from the branch-condition checker, which is registered and valid exactly one cycle after the branch condition is presented. On a taken branch it redirects the PC and discards any wrong-path fetch.

---
 rtl/fetch_unit_pkg.sv | 30 +++
 rtl/fetch_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_pkg.sv
// Utilities: shared types and helpers for the instruction fetch stage.
//   FetchState    - fetch FSM state encoding (IDLE, FETCH, RESOLVE, DRAIN)
//   INSTR_W       - instruction width in bits (16-bit instructions)
//   MAX_ADDR_W    - widest address the branch_target helper supports
//   branch_target - pc + 4 + (sign-extended imm8 << 1), wrapping modulo 2^width
package Utilities;

    localparam int INSTR_W    = 16;
    localparam int MAX_ADDR_W = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        RESOLVE = 2'd2,
        DRAIN   = 2'd3
    } FetchState;

    // Computed at the widest supported width. A caller with a narrower PC
    // truncates the result, which gives the same wrap-around as doing the
    // addition at its own width.
    function automatic logic [MAX_ADDR_W-1:0] branch_target(
        input logic [MAX_ADDR_W-1:0] pc,
        input logic [7:0]            imm8
    );
        logic [MAX_ADDR_W-1:0] offset;
        offset = {{(MAX_ADDR_W-9){imm8[7]}}, imm8, 1'b0};
        return pc + MAX_ADDR_W'(4) + offset;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, halfword instruction fetch and a one-entry
// instruction buffer towards the decoder, with conditional-branch redirect.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   en                  start fetching (only looked at in IDLE)
//   mem_req, mem_addr   fetch request and halfword address
//   mem_ack, mem_rdata  fetch completion and instruction data
//   instr, instr_pc     buffered instruction and its address
//   instr_valid         buffer holds an instruction for the decoder
//   instr_ready         decoder accepts the buffered instruction
//   br_eval, br_offset  consumed instruction is a conditional branch, imm8 offset
//   do_branch           condition result, one cycle after br_eval
//   branch_taken        one-cycle pulse when the PC is redirected
//   pc                  address of the next fetch
//   state_dbg           current FSM state (FetchState encoding)
//
// Handshakes: the decoder side is valid/ready -- an instruction transfers in
// every cycle where instr_valid && instr_ready, and instr/instr_pc stay stable
// while instr_valid is high without instr_ready. The memory side is req/ack --
// once mem_req rises, mem_req and mem_addr hold until the cycle with mem_ack,
// and mem_ack outside a request is ignored.
module fetch_unit
    import Utilities::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               br_eval,
    input  logic [7:0]         br_offset,
    input  logic               do_branch,
    output logic               branch_taken,
    output logic [ADDR_W-1:0]  pc,
    output logic [1:0]         state_dbg
);

    FetchState          state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               out_q, out_d;          // a request is outstanding
    logic [ADDR_W-1:0]  addr_q, addr_d;        // address of the outstanding request
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               valid_q, valid_d;
    logic               taken_q, taken_d;
    logic [ADDR_W-1:0]  target_q, target_d;

    logic consume;
    logic issue;
    logic ack;

    // A wrong-path instruction captured alongside the branch sits in the
    // buffer during RESOLVE but is hidden until the branch outcome is known.
    assign instr_valid = valid_q && (state_q != RESOLVE);
    assign consume     = instr_valid && instr_ready;

    // A new request goes out combinationally in the same cycle the buffer
    // frees up, so a same-cycle ack sustains one instruction per cycle.
    assign issue    = (state_q == FETCH) && !out_q && (!valid_q || consume);
    assign mem_req  = out_q || issue;
    assign mem_addr = !mem_req ? '0 : (out_q ? addr_q : pc_q);
    assign ack      = mem_req && mem_ack;

    assign instr        = instr_q;
    assign instr_pc     = instr_pc_q;
    assign branch_taken = taken_q;
    assign pc           = pc_q;
    assign state_dbg    = state_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        out_d      = out_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        taken_d    = 1'b0;
        target_d   = target_q;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = FETCH;
                end
            end

            FETCH: begin
                if (consume) begin
                    valid_d = 1'b0;
                end
                // An ack in the consume cycle reloads the buffer, so valid stays high.
                if (ack) begin
                    instr_d    = mem_rdata;
                    instr_pc_d = mem_addr;
                    valid_d    = 1'b1;
                    pc_d       = pc_q + ADDR_W'(2);
                    out_d      = 1'b0;
                end else if (mem_req) begin
                    out_d  = 1'b1;
                    addr_d = mem_addr;
                end
                if (consume && br_eval) begin
                    target_d = ADDR_W'(branch_target(MAX_ADDR_W'(instr_pc_q), br_offset));
                    state_d  = RESOLVE;
                end
            end

            RESOLVE: begin
                if (ack) begin
                    instr_d    = mem_rdata;
                    instr_pc_d = mem_addr;
                    valid_d    = 1'b1;
                    pc_d       = pc_q + ADDR_W'(2);
                    out_d      = 1'b0;
                end
                if (do_branch) begin
                    valid_d = 1'b0;
                    pc_d    = target_q;
                    taken_d = 1'b1;
                    // A still-unacked wrong-path request must finish before refetching.
                    state_d = (out_q && !mem_ack) ? DRAIN : FETCH;
                end else begin
                    state_d = FETCH;
                end
            end

            DRAIN: begin
                if (ack) begin
                    out_d   = 1'b0;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            out_q      <= 1'b0;
            addr_q     <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            taken_q    <= 1'b0;
            target_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            out_q      <= out_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            taken_q    <= taken_d;
            target_q   <= target_d;
        end
    end

    // br_eval is only meaningful on a transfer; anywhere else it is ignored.
    a_br_eval_on_consume: assert property (
        @(posedge clk) disable iff (rst) br_eval |-> (instr_valid && instr_ready)
    );

endmodule
